shared_mem_arbiter: RTL and testbench

Parametrised shared-memory subsystem serving N_PROC processor ports through one single-ported word memory. Each processor has its own request channel (command, address, write data), so no address or data bus is shared between requesters. A round-robin arbiter with a three-state access FSM serialises accesses. It is the successor to the fixed 4-processor memory subsystem and sits between the processor cores and the shared data store.

---
 rtl/shared_mem_arbiter_if.sv | 25 ++
 rtl/shared_mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_shared_mem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shared_mem_arbiter_if.sv
// Processor-side bundle of the shared memory subsystem: per-port request
// channels in, shared response channel out.
interface shared_mem_arbiter_if #(
  parameter int unsigned N_PROC = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 14
);
  logic [N_PROC-1:0]        proc_req;
  logic [N_PROC-1:0]        proc_we;
  logic [N_PROC*ADDR_W-1:0] proc_addr;
  logic [N_PROC*DATA_W-1:0] proc_wdata;
  logic [N_PROC-1:0]        proc_resp;
  logic [DATA_W-1:0]        proc_rdata;
  logic                     proc_err;

  modport master (
    output proc_req, proc_we, proc_addr, proc_wdata,
    input  proc_resp, proc_rdata, proc_err
  );

  modport slave (
    input  proc_req, proc_we, proc_addr, proc_wdata,
    output proc_resp, proc_rdata, proc_err
  );
endinterface

// File: rtl/shared_mem_arbiter.sv
// Round-robin arbitrated single-ported word memory shared by N_PROC ports.
// IDLE -> ACCESS -> RESP per access; request fields are latched at grant.
// Optional: define SHMEM_ADDR_CHECK_EN to flag out-of-range accesses on proc_err.
module shared_mem_arbiter #(
  parameter int unsigned N_PROC = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DEPTH  = 4096
) (
  input  logic                clk,
  input  logic                reset_n,
  shared_mem_arbiter_if.slave bus
);
  localparam int unsigned IDX_W  = (N_PROC > 1) ? $clog2(N_PROC) : 1;
  localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    winner_q, winner_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [N_PROC-1:0]   resp_q, resp_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic                found_hi_c, found_lo_c, found_c;
  logic [IDX_W-1:0]    pick_hi_c, pick_lo_c, pick_c;
  logic                sel_we_c;
  logic [ADDR_W-1:0]   sel_addr_c;
  logic [DATA_W-1:0]   sel_wdata_c;
  logic                in_range_c;
  logic [MEM_AW-1:0]   mem_idx_c;
  logic                mem_we_c;

  logic [DATA_W-1:0]   mem [DEPTH];

  // Round-robin pick: first requester at/above the pointer, else first overall
  always_comb begin
    found_hi_c = 1'b0;
    found_lo_c = 1'b0;
    pick_hi_c  = '0;
    pick_lo_c  = '0;
    for (int i = 0; i < N_PROC; i++) begin
      if (!found_hi_c && bus.proc_req[i] && (32'(i) >= 32'(ptr_q))) begin
        found_hi_c = 1'b1;
        pick_hi_c  = IDX_W'(i);
      end
      if (!found_lo_c && bus.proc_req[i]) begin
        found_lo_c = 1'b1;
        pick_lo_c  = IDX_W'(i);
      end
    end
    found_c = found_hi_c | found_lo_c;
    pick_c  = found_hi_c ? pick_hi_c : pick_lo_c;
  end

  // Command fields of the selected port
  always_comb begin
    sel_we_c    = 1'b0;
    sel_addr_c  = '0;
    sel_wdata_c = '0;
    for (int i = 0; i < N_PROC; i++) begin
      if (pick_c == IDX_W'(i)) begin
        sel_we_c    = bus.proc_we[i];
        sel_addr_c  = bus.proc_addr[i*ADDR_W +: ADDR_W];
        sel_wdata_c = bus.proc_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Decode of the latched address
  always_comb begin
    in_range_c = (32'(addr_q) < DEPTH);
    mem_idx_c  = MEM_AW'(addr_q);
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    ptr_d    = ptr_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    resp_d   = '0;
    rdata_d  = rdata_q;
    err_d    = err_q;
    mem_we_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (found_c) begin
          winner_d = pick_c;
          ptr_d    = (32'(pick_c) == N_PROC - 1) ? '0 : pick_c + IDX_W'(1);
          we_d     = sel_we_c;
          addr_d   = sel_addr_c;
          wdata_d  = sel_wdata_c;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        mem_we_c = we_q && in_range_c;
        for (int i = 0; i < N_PROC; i++) begin
          resp_d[i] = (winner_q == IDX_W'(i));
        end
        if (!in_range_c) begin
          rdata_d = '0;
        end else if (we_q) begin
          rdata_d = wdata_q;
        end else begin
          rdata_d = mem[mem_idx_c];
        end
`ifdef SHMEM_ADDR_CHECK_EN
        err_d = !in_range_c;
`else
        err_d = 1'b0;
`endif
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      winner_q <= '0;
      ptr_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      resp_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      ptr_q    <= ptr_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      resp_q   <= resp_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Memory array write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[mem_idx_c] <= wdata_q;
    end
  end

  assign bus.proc_resp  = resp_q;
  assign bus.proc_rdata = rdata_q;
  assign bus.proc_err   = err_q;
endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Scoreboard bench for shared_mem_arbiter: the driver predicts grant order,
// data and response cycle for each batch; a negedge monitor checks responses.
module tb_shared_mem_arbiter;
  localparam int N     = 4;
  localparam int DW    = 16;
  localparam int AW    = 14;
  localparam int DEPTH = 4096;
`ifdef SHMEM_ADDR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  shared_mem_arbiter_if #(.N_PROC(N), .DATA_W(DW), .ADDR_W(AW)) bus ();

  shared_mem_arbiter #(.N_PROC(N), .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int          port;
    logic [DW-1:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t          expq[$];
  logic [DW-1:0] ref_mem [DEPTH];
  bit            ref_written [DEPTH];
  int            written_list[$];
  int            ref_ptr = 0;
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;

  int            b_cnt  [N];
  bit            b_we   [N];
  int            b_addr [N];
  logic [DW-1:0] b_wd   [N];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every response is popped against the scoreboard
  exp_t mon_e;
  always @(negedge clk) begin
    if (reset_n && bus.proc_resp !== '0) begin
      chk("resp_onehot", 32'($onehot(bus.proc_resp)), 32'd1);
      if (expq.size() == 0) begin
        chk("unexpected_resp", 32'(bus.proc_resp), 32'd0);
      end else begin
        mon_e = expq.pop_front();
        chk("resp_port", 32'(bus.proc_resp), 32'd1 << mon_e.port);
        chk("rdata", 32'(bus.proc_rdata), 32'(mon_e.rdata));
        chk("err", 32'(bus.proc_err), 32'(mon_e.err));
        chk("resp_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  task automatic drive_port(input int i, input bit req, input bit we, input int addr,
                            input logic [DW-1:0] wd);
    bus.proc_req[i]             = req;
    bus.proc_we[i]              = we;
    bus.proc_addr[i*AW +: AW]   = AW'(addr);
    bus.proc_wdata[i*DW +: DW]  = wd;
  endtask

  // Reference behaviour of one access, pushed onto the scoreboard
  task automatic model_access(input int i, input bit we, input int addr,
                              input logic [DW-1:0] wd, input int exp_cyc);
    exp_t e;
    bit   inr;
    inr     = (addr < DEPTH);
    e.port  = i;
    e.err   = ERR_EN && !inr;
    e.cyc   = exp_cyc;
    if (!inr) begin
      e.rdata = '0;
    end else if (we) begin
      ref_mem[addr] = wd;
      if (!ref_written[addr]) begin
        ref_written[addr] = 1'b1;
        written_list.push_back(addr);
      end
      e.rdata = wd;
    end else begin
      e.rdata = ref_mem[addr];
    end
    expq.push_back(e);
  endtask

  task automatic clear_batch();
    for (int i = 0; i < N; i++) begin
      b_cnt[i] = 0; b_we[i] = 1'b0; b_addr[i] = 0; b_wd[i] = '0;
    end
  endtask

  // Issue a batch (port i performs b_cnt[i] identical accesses, holding req)
  // Called at a negedge with the DUT idle at the next rising edge.
  task automatic run_batch();
    int rem [N];
    int total;
    int c0;
    int budget;
    int left_sum;
    total = 0;
    c0 = cyc;
    for (int i = 0; i < N; i++) begin
      rem[i] = b_cnt[i];
      total += b_cnt[i];
    end
    for (int j = 0; j < total; j++) begin
      int g;
      g = -1;
      for (int off = 0; off < N; off++) begin
        int p;
        p = (ref_ptr + off) % N;
        if (g < 0 && rem[p] > 0) g = p;
      end
      rem[g]--;
      ref_ptr = (g + 1) % N;
      model_access(g, b_we[g], b_addr[g], b_wd[g], c0 + 2 + 3 * j);
    end
    for (int i = 0; i < N; i++) begin
      rem[i] = b_cnt[i];
      if (b_cnt[i] > 0) drive_port(i, 1'b1, b_we[i], b_addr[i], b_wd[i]);
    end
    budget = 3 * total + 10;
    left_sum = total;
    while (budget > 0 && left_sum > 0) begin
      @(negedge clk);
      budget--;
      for (int i = 0; i < N; i++) begin
        if (rem[i] > 0 && bus.proc_resp[i] === 1'b1) begin
          rem[i]--;
          left_sum--;
          if (rem[i] == 0) drive_port(i, 1'b0, b_we[i], b_addr[i], b_wd[i]);
        end
      end
    end
    if (left_sum > 0) begin
      chk("batch_timeout", 32'(left_sum), 32'd0);
      for (int i = 0; i < N; i++) drive_port(i, 1'b0, 1'b0, 0, '0);
      expq.delete();
      repeat (4) @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int done;
    bus.proc_req   = '0;
    bus.proc_we    = '0;
    bus.proc_addr  = '0;
    bus.proc_wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_resp", 32'(bus.proc_resp), 32'd0);
    chk("reset_rdata", 32'(bus.proc_rdata), 32'd0);
    chk("reset_err", 32'(bus.proc_err), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Contention from reset: grants 0,1,2,3 spaced 3 cycles
    clear_batch();
    for (int i = 0; i < N; i++) begin
      b_cnt[i] = 1; b_we[i] = 1'b1; b_addr[i] = i; b_wd[i] = DW'(16'h1000 + i);
    end
    run_batch();
    clear_batch();
    for (int i = 0; i < N; i++) begin
      b_cnt[i] = 1; b_addr[i] = i;
    end
    run_batch();

    // Single write then read from another port
    clear_batch(); b_cnt[0] = 1; b_we[0] = 1'b1; b_addr[0] = 100; b_wd[0] = 16'hBEEF;
    run_batch();
    clear_batch(); b_cnt[2] = 1; b_addr[2] = 100;
    run_batch();

    // Fairness: ports 1 and 3 requesting continuously
    clear_batch(); b_cnt[1] = 4; b_addr[1] = 1; b_cnt[3] = 4; b_addr[3] = 3;
    run_batch();

    // Out-of-range write/read leaves the aliased word alone
    clear_batch(); b_cnt[0] = 1; b_we[0] = 1'b1; b_addr[0] = 904; b_wd[0] = 16'h1234;
    run_batch();
    clear_batch(); b_cnt[1] = 1; b_we[1] = 1'b1; b_addr[1] = 5000; b_wd[1] = 16'h5555;
    run_batch();
    clear_batch(); b_cnt[1] = 1; b_addr[1] = 5000;
    run_batch();
    clear_batch(); b_cnt[2] = 1; b_addr[2] = 904;
    run_batch();

    // Reset during ACCESS of a port-3 read
    drive_port(3, 1'b1, 1'b0, 100, '0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst_access_resp", 32'(bus.proc_resp), 32'd0);
    chk("rst_access_rdata", 32'(bus.proc_rdata), 32'd0);
    chk("rst_access_err", 32'(bus.proc_err), 32'd0);
    drive_port(3, 1'b0, 1'b0, 0, '0);
    ref_ptr = 0;
    expq.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset while a port-1 response is on the bus
    model_access(1, 1'b0, 100, '0, cyc + 2);
    drive_port(1, 1'b1, 1'b0, 100, '0);
    repeat (2) @(negedge clk);
    drive_port(1, 1'b0, 1'b0, 0, '0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_resp_resp", 32'(bus.proc_resp), 32'd0);
    chk("rst_resp_rdata", 32'(bus.proc_rdata), 32'd0);
    chk("rst_resp_err", 32'(bus.proc_err), 32'd0);
    chk("rst_resp_pending", 32'(expq.size()), 32'd0);
    ref_ptr = 0;
    expq.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Pointer back at 0: port 0 before port 3
    clear_batch(); b_cnt[0] = 1; b_addr[0] = 0; b_cnt[3] = 1; b_addr[3] = 3;
    run_batch();

    // Random regression
    done = 0;
    while (done < 1000) begin
      clear_batch();
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          b_cnt[i] = $urandom_range(1, 2);
          if (written_list.size() == 0 || $urandom_range(0, 1) == 1) begin
            b_we[i]   = 1'b1;
            b_addr[i] = $urandom_range(0, 3999);
            b_wd[i]   = DW'($urandom);
          end else begin
            b_addr[i] = written_list[$urandom_range(0, written_list.size() - 1)];
          end
        end
      end
      if (b_cnt[0] + b_cnt[1] + b_cnt[2] + b_cnt[3] == 0) begin
        b_cnt[0] = 1; b_we[0] = 1'b1; b_addr[0] = $urandom_range(0, 3999); b_wd[0] = DW'($urandom);
      end
      done += b_cnt[0] + b_cnt[1] + b_cnt[2] + b_cnt[3];
      run_batch();
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
